dsp_mac_pipe: RTL and testbench

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe
// Three-stage pipelined pre-add / multiply / post-add-accumulate block with
// valid/ready flow control. One beat per cycle when downstream keeps up.
//
// Stage 1: pre = opmode[0] ? (opmode[1] ? D-B : D+B) : B    (BW+1 bits)
// Stage 2: M   = A * pre                                     (AW+BW+1 bits)
// Stage 3: Z   = {0, C, acc, 0}[opmode[3:2]]
//          P   = opmode[4] ? Z-(M+carryin) : Z+M+carryin      (PW+1 bits)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_ready  input beat handshake (in_ready = !out_valid | out_ready)
//   A, B, D, C          signed operands (AW, BW, BW, PW bits)
//   carryin, opmode     post-adder carry and per-beat operation select
//   out_valid, out_ready output handshake
//   P, ovf              result and its signed-overflow flag
//   ovf_sticky          OR of ovf over every beat taken downstream
//
// Build option: define DSP_MAC_SAT_EN to clamp P/acc on overflow instead of
// wrapping to the low PW bits.
//
// Parameter constraint: PW must be at least AW+BW+3.

module dsp_mac_pipe #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic [BW-1:0] D,
  input  logic [PW-1:0] C,
  input  logic          carryin,
  input  logic [4:0]    opmode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] P,
  output logic          ovf,
  output logic          ovf_sticky
);

  localparam int MW = AW + BW + 1;

  // The whole pipe moves as one unit: it advances whenever the output slot
  // is empty or being drained this cycle.
  logic adv;
  assign adv      = !outValid_q | out_ready;
  assign in_ready = adv;

  // ---------------- Stage 1: pre-adder ----------------
  logic          s1Valid_q;
  logic [AW-1:0] s1A_q;
  logic [PW-1:0] s1C_q;
  logic          s1Cin_q;
  logic [4:0]    s1Op_q;
  logic [BW:0]   s1Pre_q;
  logic [BW:0]   s1Pre_d;
  logic [BW:0]   bExt;
  logic [BW:0]   dExt;

  // Operands are sign-extended by one bit so the sum/difference never truncates.
  always_comb begin
    bExt    = {B[BW-1], B};
    dExt    = {D[BW-1], D};
    s1Pre_d = bExt;
    if (opmode[0]) begin
      s1Pre_d = opmode[1] ? (dExt - bExt) : (dExt + bExt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1C_q     <= '0;
      s1Cin_q   <= 1'b0;
      s1Op_q    <= '0;
      s1Pre_q   <= '0;
    end else if (adv) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1A_q   <= A;
        s1C_q   <= C;
        s1Cin_q <= carryin;
        s1Op_q  <= opmode;
        s1Pre_q <= s1Pre_d;
      end
    end
  end

  // ---------------- Stage 2: multiplier ----------------
  logic          s2Valid_q;
  logic [MW-1:0] s2M_q;
  logic [MW-1:0] s2M_d;
  logic [PW-1:0] s2C_q;
  logic          s2Cin_q;
  logic [4:0]    s2Op_q;
  logic [MW-1:0] aWide;
  logic [MW-1:0] preWide;

  // Both factors are sign-extended to the full product width, so an unsigned
  // multiply truncated to MW bits yields the exact signed product.
  always_comb begin
    aWide   = {{(BW + 1){s1A_q[AW-1]}}, s1A_q};
    preWide = {{AW{s1Pre_q[BW]}}, s1Pre_q};
    s2M_d   = aWide * preWide;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2M_q     <= '0;
      s2C_q     <= '0;
      s2Cin_q   <= 1'b0;
      s2Op_q    <= '0;
    end else if (adv) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2M_q   <= s2M_d;
        s2C_q   <= s1C_q;
        s2Cin_q <= s1Cin_q;
        s2Op_q  <= s1Op_q;
      end
    end
  end

  // ---------------- Stage 3: post-adder / accumulator ----------------
  logic          outValid_q;
  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;
  logic          ovf_q;
  logic          ovf_d;
  logic [PW-1:0] acc_q;
  logic          sticky_q;
  logic [PW:0]   mExt;
  logic [PW:0]   zExt;
  logic [PW:0]   cinExt;
  logic [PW:0]   sum;

  // One guard bit above PW holds any Z +/- (M + carryin) exactly; overflow is
  // the guard bit disagreeing with the PW-bit sign bit.
  always_comb begin
    mExt   = {{(PW + 1 - MW){s2M_q[MW-1]}}, s2M_q};
    cinExt = {{PW{1'b0}}, s2Cin_q};
    zExt   = '0;
    case (s2Op_q[3:2])
      2'b01:   zExt = {s2C_q[PW-1], s2C_q};
      2'b10:   zExt = {acc_q[PW-1], acc_q};
      default: zExt = '0;
    endcase
    sum   = s2Op_q[4] ? (zExt - (mExt + cinExt)) : (zExt + mExt + cinExt);
    ovf_d = sum[PW] ^ sum[PW-1];
`ifdef DSP_MAC_SAT_EN
    if (ovf_d) begin
      p_d = sum[PW] ? {1'b1, {(PW - 1){1'b0}}} : {1'b0, {(PW - 1){1'b1}}};
    end else begin
      p_d = sum[PW-1:0];
    end
`else
    p_d = sum[PW-1:0];
`endif
  end

  // acc follows P but only when a real beat lands, so bubbles and stalls never
  // disturb a running accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      p_q        <= '0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
    end else if (adv) begin
      outValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
        acc_q <= p_d;
      end
    end
  end

  // Sticky flag records overflow only for results actually taken downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (outValid_q && out_ready && ovf_q) begin
      sticky_q <= 1'b1;
    end
  end

  assign out_valid  = outValid_q;
  assign P          = p_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed testbench for dsp_mac_pipe: single-beat vector table plus hand
// sequences for accumulation, output stall, and asynchronous reset.
// Works for both builds; expected overflow results follow DSP_MAC_SAT_EN.

module tb_dsp_mac_pipe;

  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 48;

  localparam logic signed [PW-1:0] MAXP = 48'sh7FFF_FFFF_FFFF;
  localparam logic signed [PW-1:0] MINP = 48'sh8000_0000_0000;
`ifdef DSP_MAC_SAT_EN
  localparam logic signed [PW-1:0] OVF_POS_P = MAXP;
  localparam logic signed [PW-1:0] OVF_NEG_P = MINP;
`else
  localparam logic signed [PW-1:0] OVF_POS_P = MINP;
  localparam logic signed [PW-1:0] OVF_NEG_P = MAXP;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [AW-1:0] A;
  logic signed [BW-1:0] B;
  logic signed [BW-1:0] D;
  logic signed [PW-1:0] C;
  logic                 carryin;
  logic [4:0]           opmode;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [PW-1:0] P;
  logic                 ovf;
  logic                 ovf_sticky;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic signed [AW-1:0] a;
    logic signed [BW-1:0] b;
    logic signed [BW-1:0] d;
    logic signed [PW-1:0] c;
    logic                 cin;
    logic [4:0]           op;
    logic signed [PW-1:0] expP;
    logic                 expOvf;
  } vec_t;

  vec_t vecs[9];

  dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .D         (D),
    .C         (C),
    .carryin   (carryin),
    .opmode    (opmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .ovf       (ovf),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    A        = v.a;
    B        = v.b;
    D        = v.d;
    C        = v.c;
    carryin  = v.cin;
    opmode   = v.op;
    in_valid = 1'b1;
  endtask

  // Four accumulate beats (20,40,60,80). When stallLen > 0, out_ready is held
  // low for that many cycles while the second result sits on P.
  task automatic runStream(input int stallLen);
    logic signed [PW-1:0] exp[4];
    int sent;
    int got;
    int stallLeft;
    int cyc;
    exp[0] = 48'sd20;
    exp[1] = 48'sd40;
    exp[2] = 48'sd60;
    exp[3] = 48'sd80;
    sent = 0;
    got = 0;
    stallLeft = stallLen;
    cyc = 0;
    out_ready = 1'b1;
    while (got < 4 && cyc < 40) begin
      if (out_valid && got == 1 && stallLeft > 0) begin
        out_ready = 1'b0;
        #1;
        checkOutput("stallInReady", in_ready, 0);
        checkOutput("stallHoldP", P, exp[1]);
        stallLeft--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          checkOutput($sformatf("streamP%0d", got), P, exp[got]);
          got++;
        end
      end
      if (sent < 4) begin
        A        = 18'sd2;
        B        = 18'sd10;
        D        = 18'sd0;
        C        = 48'sd0;
        carryin  = 1'b0;
        opmode   = (sent == 0) ? 5'b00000 : 5'b01000;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) sent++;
      step(1);
      cyc++;
    end
    if (got < 4) checkOutput("streamTimeout", got, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{18'sd3, 18'sd4, 18'sd5, 48'sd100, 1'b1, 5'b00101, 48'sd128, 1'b0};
    vecs[1] = '{-18'sd2, 18'sd7, 18'sd3, 48'sd0, 1'b0, 5'b10011, -48'sd8, 1'b0};
    vecs[2] = '{-18'sd5, -18'sd100, 18'sd50, 48'sd1000, 1'b1, 5'b00111, 48'sd251, 1'b0};
    vecs[3] = '{18'sd7, 18'sd6, 18'sd0, -48'sd20, 1'b0, 5'b10100, -48'sd62, 1'b0};
    vecs[4] = '{18'sd100, -18'sd3, -18'sd4, 48'sd999, 1'b1, 5'b01101, -48'sd699, 1'b0};
    vecs[5] = '{-18'sd131072, -18'sd131072, -18'sd131072, 48'sd0, 1'b0, 5'b00001,
                48'sd34359738368, 1'b0};
    vecs[6] = '{18'sd1, 18'sd1, 18'sd0, MAXP - 48'sd1, 1'b0, 5'b00100, MAXP, 1'b0};
    vecs[7] = '{18'sd1, 18'sd1, 18'sd0, MAXP, 1'b0, 5'b00100, OVF_POS_P, 1'b1};
    vecs[8] = '{18'sd1, 18'sd1, 18'sd0, MINP, 1'b0, 5'b10100, OVF_NEG_P, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    D         = '0;
    C         = '0;
    carryin   = 1'b0;
    opmode    = '0;

    #12;
    checkOutput("rstOutValid", out_valid, 0);
    checkOutput("rstP", P, 0);
    checkOutput("rstOvf", ovf, 0);
    checkOutput("rstSticky", ovf_sticky, 0);
    checkOutput("rstInReady", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    $display("[TB] accumulate stream, no stall");
    runStream(0);
    checkOutput("stickyClear", ovf_sticky, 0);

    $display("[TB] accumulate stream with 4-cycle output stall");
    runStream(4);
    step(1);
    checkOutput("afterStreamIdle", out_valid, 0);

    $display("[TB] single-beat vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      step(1);
      in_valid = 1'b0;
      step(1);
      checkOutput($sformatf("vec%0d_early", i), out_valid, 0);
      step(1);
      checkOutput($sformatf("vec%0d_valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d_P", i), P, vecs[i].expP);
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].expOvf);
      step(1);
      checkOutput($sformatf("vec%0d_bubble", i), out_valid, 0);
      checkOutput($sformatf("vec%0d_hold", i), P, vecs[i].expP);
    end
    checkOutput("stickySet", ovf_sticky, 1);

    $display("[TB] asynchronous reset with beats in flight");
    for (int i = 0; i < 4; i++) begin
      A        = 18'sd2;
      B        = 18'sd10;
      D        = 18'sd0;
      C        = 48'sd0;
      carryin  = 1'b0;
      opmode   = 5'b01000;
      in_valid = 1'b1;
      step(1);
    end
    checkOutput("preRstValid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", out_valid, 0);
    checkOutput("asyncRstP", P, 0);
    checkOutput("asyncRstSticky", ovf_sticky, 0);
    checkOutput("asyncRstInReady", in_ready, 1);
    @(negedge clk);
    A        = 18'sd1;
    B        = 18'sd1;
    D        = 18'sd0;
    C        = 48'sd0;
    carryin  = 1'b0;
    opmode   = 5'b01000;
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    step(1);
    in_valid = 1'b0;
    step(1);
    checkOutput("postRstEarly", out_valid, 0);
    step(1);
    checkOutput("postRstValid", out_valid, 1);
    checkOutput("postRstP", P, 1);
    checkOutput("postRstOvf", ovf, 0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
